// File: rtl/fir_pkg.sv
// Shared FIR types: accumulator/address widths and the result-reader state encoding.
package fir_pkg;

  localparam int FIR_ADDR_W = 11;
  localparam int FIR_ACC_W  = 93;

  typedef logic signed [FIR_ACC_W-1:0] fir_acc_t;
  typedef logic        [FIR_ADDR_W-1:0] fir_addr_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN,
    RD_DONE
  } rd_state_t;

endpackage

// File: rtl/fir_sat_round.sv
// Combinational round-half-up, arithmetic right shift and saturation of one accumulator word.
module fir_sat_round #(
  parameter int DATA_W = 93,
  parameter int OUT_W  = 24,
  parameter int SHIFT  = 40
) (
  input  logic signed [DATA_W-1:0] din,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     sat
);

  localparam logic signed [DATA_W:0] RND  = {{DATA_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [DATA_W:0] MAXV = {{(DATA_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] MINV = {{(DATA_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // One guard bit above the accumulator keeps the rounding add from overflowing.
  function automatic logic signed [DATA_W:0] round_shift(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] ext;
    ext = {x[DATA_W-1], x} + RND;
    return ext >>> SHIFT;
  endfunction

  // Packs {sat, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [DATA_W:0] r);
    if (r > MAXV) begin
      return {1'b1, MAXV[OUT_W-1:0]};
    end else if (r < MINV) begin
      return {1'b1, MINV[OUT_W-1:0]};
    end else begin
      return {1'b0, r[OUT_W-1:0]};
    end
  endfunction

  assign {sat, dout} = saturate(round_shift(din));

endmodule

// File: rtl/fir_result_reader.sv
// Sweeps the FIR output RAM, absorbs its read latency, rounds/saturates each word and
// streams the results in address order on a valid/ready port.
module fir_result_reader
  import fir_pkg::*;
#(
  parameter int ADDR_W  = FIR_ADDR_W,
  parameter int DATA_W  = FIR_ACC_W,
  parameter int OUT_W   = 24,
  parameter int SHIFT   = 40,
  parameter int RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  // One extra bit so a full 2**ADDR_W sweep can be requested; larger values clamp to full.
  input  logic [ADDR_W:0]          num_samples,
  output logic                     ram_read_en,
  output logic [ADDR_W-1:0]        ram_address,
  input  logic signed [DATA_W-1:0] ram_data,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag
);

  localparam int CNT_W = $clog2(RAM_LAT + 4);

  rd_state_t state, state_nxt;

  logic [ADDR_W-1:0]       rd_ptr, last_addr, addr_cur, last_cur;
  logic [RAM_LAT-1:0]      tag_vld_p1;
  logic [CNT_W-1:0]        in_flight, occ;
  logic                    accept, issue, issue_last, ret, pop;
  logic signed [OUT_W-1:0] sr_data;
  logic                    sr_sat;

  logic signed [OUT_W-1:0] buf_mem [2];
  logic                    buf_wr, buf_rd;
  logic [1:0]              buf_cnt;

  // ---- issue stage: address generation and credit check ----
  assign accept   = (state == RD_IDLE) && start && !rst;
  assign addr_cur = (state == RD_IDLE) ? '0 : rd_ptr;
  assign last_cur = (state == RD_IDLE)
                  ? (num_samples[ADDR_W] ? {ADDR_W{1'b1}} : num_samples[ADDR_W-1:0] - 1'b1)
                  : last_addr;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      in_flight = in_flight + CNT_W'(tag_vld_p1[i]);
    end
  end

  // Credits count the word leaving this cycle as already gone, which keeps the stream
  // bubble-free at RAM_LAT=1 while never letting reads+buffered exceed the two buffer slots.
  assign pop   = m_valid && m_ready;
  assign occ   = in_flight + CNT_W'(buf_cnt) - CNT_W'(pop);
  assign issue = accept ? (num_samples != '0)
                        : ((state == RD_READ) && (occ < CNT_W'(2)));
  assign issue_last = issue && (addr_cur == last_cur);

  assign ram_read_en = issue;
  assign ram_address = addr_cur;

  // ---- return stage: latency tags and rounding ----
  assign ret = tag_vld_p1[RAM_LAT-1];

  fir_sat_round #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_sat_round (
    .din  (ram_data),
    .dout (sr_data),
    .sat  (sr_sat)
  );

  // ---- output stage: 2-entry skid buffer ----
  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = m_valid ? buf_mem[buf_rd] : '0;
  assign busy    = (state == RD_READ) || (state == RD_DRAIN);
  assign done    = (state == RD_DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      RD_IDLE: begin
        if (accept) begin
          if (num_samples == '0)  state_nxt = RD_DONE;
          else if (issue_last)    state_nxt = RD_DRAIN;
          else                    state_nxt = RD_READ;
        end
      end
      RD_READ:  if (issue_last) state_nxt = RD_DRAIN;
      RD_DRAIN: if (pop && (buf_cnt == 2'd1) && (in_flight == '0)) state_nxt = RD_DONE;
      RD_DONE:  state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RD_IDLE;
      rd_ptr     <= '0;
      last_addr  <= '0;
      tag_vld_p1 <= '0;
      buf_wr     <= 1'b0;
      buf_rd     <= 1'b0;
      buf_cnt    <= 2'd0;
      sat_flag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tag_vld_p1 <= (tag_vld_p1 << 1) | RAM_LAT'(issue);
      if (accept) last_addr <= last_cur;
      if (issue && !issue_last) rd_ptr <= addr_cur + 1'b1;
      if (ret) buf_wr <= ~buf_wr;
      if (pop) buf_rd <= ~buf_rd;
      buf_cnt <= buf_cnt + 2'(ret) - 2'(pop);
      if (accept) sat_flag <= 1'b0;
      else if (ret && sr_sat) sat_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ret) buf_mem[buf_wr] <= sr_data;
  end

endmodule

// File: tb/tb_fir_result_reader.sv
// Self-checking bench for fir_result_reader: RAM model, transfer monitor, reference rounding model.
module tb_fir_result_reader;
  import fir_pkg::*;

  localparam int N = 2048;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic                    m_ready = 1'b1;
  logic [11:0]             num_samples = '0;
  logic                    ram_read_en;
  logic [10:0]             ram_address;
  fir_acc_t                ram_data = '0;
  logic signed [23:0]      m_data;
  logic                    m_valid, busy, done, sat_flag;

  fir_acc_t                mem [N];
  int                      errors = 0;
  int                      checks = 0;
  int                      cyc = 0;

  logic signed [23:0]      got[$];
  int                      got_cyc[$];
  int                      addr_log[$];
  int                      outstanding = 0;
  int                      occ_viol = 0;
  int                      stab_viol = 0;
  int                      done_cnt = 0;
  bit                      hold_pend = 0;
  logic signed [23:0]      held = '0;

  fir_result_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .ram_read_en (ram_read_en),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_read_en) ram_data <= mem[ram_address];

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      hold_pend   = 0;
    end else begin
      if (ram_read_en) begin
        addr_log.push_back(int'(ram_address));
        outstanding++;
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
        outstanding--;
      end
      if (outstanding > 2) occ_viol++;
      if (hold_pend && (!m_valid || m_data !== held)) stab_viol++;
      hold_pend = m_valid && !m_ready;
      held      = m_data;
      if (done) done_cnt++;
    end
  end

  // Reference: floor((v + 2^39) / 2^40), clipped to the signed 24-bit range.
  function automatic void model_word(input fir_acc_t v, output logic signed [23:0] q, output bit s);
    logic signed [127:0] w;
    w = v;
    w = (w + (128'sd1 <<< 39)) >>> 40;
    if (w > 128'sd8388607) begin
      q = 24'sd8388607; s = 1;
    end else if (w < -128'sd8388608) begin
      q = -24'sd8388608; s = 1;
    end else begin
      q = w[23:0]; s = 0;
    end
  endfunction

  function automatic fir_acc_t rand_acc();
    logic signed [24:0] s;
    logic [95:0]        r;
    if ($urandom_range(3) == 0) begin
      r = {$urandom, $urandom, $urandom};
      return fir_acc_t'(r[92:0]);
    end
    s = 25'($urandom);
    return {{28{s[24]}}, s, $urandom, 8'($urandom)};
  endfunction

  task automatic run_sweep(input int n, input int rdy_pct, input int max_cyc,
                           output int start_cyc, output bit timed_out);
    int base;
    base = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; num_samples = 12'(n); start_cyc = cyc;
    m_ready = ($urandom_range(99) < rdy_pct);
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1;
    for (int c = 0; c < max_cyc; c++) begin
      m_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk); #1;
      if (done_cnt != base) begin
        timed_out = 0;
        break;
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0)     begin errors++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (sat_flag !== 1'b0)    begin errors++; $display("FAIL reset_sat got=%b want=0", sat_flag); end
    checks++; if (ram_read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en got=%b want=0", ram_read_en); end
    checks++; if (ram_address !== '0)   begin errors++; $display("FAIL reset_addr got=%0d want=0", ram_address); end
    checks++; if (m_data !== '0)        begin errors++; $display("FAIL reset_m_data got=%0d want=0", m_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int k, b, d;
    bit to, s;
    logic signed [23:0] q;
    for (int i = 0; i < 4; i++) mem[i] = fir_acc_t'(i) <<< 40;
    b = got.size(); d = done_cnt;
    run_sweep(4, 100, 50, k, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got=no_done want=done"); end
    checks++; if (got.size() - b != 4) begin errors++; $display("FAIL basic_count got=%0d want=4", got.size() - b); end
    for (int i = 0; i < 4 && b + i < got.size(); i++) begin
      model_word(mem[i], q, s);
      checks++; if (got[b+i] !== q) begin errors++; $display("FAIL basic_data[%0d] got=%0d want=%0d", i, got[b+i], q); end
      checks++; if (got_cyc[b+i] != k + 2 + i) begin errors++; $display("FAIL basic_timing[%0d] got=%0d want=%0d", i, got_cyc[b+i], k + 2 + i); end
    end
    repeat (2) @(negedge clk); #1;
    checks++; if (done_cnt - d != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - d); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b want=0", sat_flag); end
  endtask

  task automatic test_saturate();
    int k, b;
    bit to;
    mem[0] = fir_acc_t'(93'sd8388608) <<< 40;
    mem[1] = -(fir_acc_t'(93'sd8388613) <<< 40);
    b = got.size();
    run_sweep(2, 100, 50, k, to);
    checks++; if (to) begin errors++; $display("FAIL sat_timeout got=no_done want=done"); end
    checks++; if (got.size() - b != 2) begin errors++; $display("FAIL sat_count got=%0d want=2", got.size() - b); end
    if (got.size() - b >= 2) begin
      checks++; if (got[b] !== 24'sd8388607)    begin errors++; $display("FAIL sat_pos got=%0d want=8388607", got[b]); end
      checks++; if (got[b+1] !== -24'sd8388608) begin errors++; $display("FAIL sat_neg got=%0d want=-8388608", got[b+1]); end
    end
    repeat (5) @(negedge clk);
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b want=1", sat_flag); end
  endtask

  task automatic test_round();
    int k, b;
    bit to;
    logic signed [23:0] want [3];
    mem[0] = (fir_acc_t'(3) <<< 40) + (fir_acc_t'(1) <<< 39);
    mem[1] = (fir_acc_t'(3) <<< 40) + (fir_acc_t'(1) <<< 39) - fir_acc_t'(1);
    mem[2] = -(fir_acc_t'(1) <<< 39);
    want[0] = 24'sd4; want[1] = 24'sd3; want[2] = 24'sd0;
    b = got.size();
    run_sweep(3, 100, 50, k, to);
    checks++; if (to) begin errors++; $display("FAIL round_timeout got=no_done want=done"); end
    checks++; if (got.size() - b != 3) begin errors++; $display("FAIL round_count got=%0d want=3", got.size() - b); end
    for (int i = 0; i < 3 && b + i < got.size(); i++) begin
      checks++; if (got[b+i] !== want[i]) begin errors++; $display("FAIL round[%0d] got=%0d want=%0d", i, got[b+i], want[i]); end
    end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL round_sat_cleared got=%b want=0", sat_flag); end
  endtask

  task automatic test_empty();
    int a, b, d;
    a = addr_log.size(); b = got.size(); d = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; num_samples = '0;
    @(negedge clk);
    checks++; if (ram_read_en !== 1'b0) begin errors++; $display("FAIL empty_read_en got=%b want=0", ram_read_en); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1)    begin errors++; $display("FAIL empty_done got=%b want=1", done); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL empty_busy_in_done got=%b want=0", busy); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL empty_m_valid got=%b want=0", m_valid); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_width got=%b want=0", done); end
    repeat (3) @(negedge clk); #1;
    checks++; if (addr_log.size() != a) begin errors++; $display("FAIL empty_reads got=%0d want=0", addr_log.size() - a); end
    checks++; if (got.size() != b)      begin errors++; $display("FAIL empty_words got=%0d want=0", got.size() - b); end
    checks++; if (done_cnt - d != 1)    begin errors++; $display("FAIL empty_done_count got=%0d want=1", done_cnt - d); end
  endtask

  task automatic test_long();
    int k, a, b, d, ov, sv;
    bit to, s, any_sat;
    logic signed [23:0] q;
    for (int i = 0; i < N; i++) mem[i] = rand_acc();
    a = addr_log.size(); b = got.size(); d = done_cnt; ov = occ_viol; sv = stab_viol;
    any_sat = 0;
    run_sweep(N, 50, 20000, k, to);
    checks++; if (to) begin errors++; $display("FAIL long_timeout got=no_done want=done"); end
    checks++; if (got.size() - b != N)      begin errors++; $display("FAIL long_count got=%0d want=%0d", got.size() - b, N); end
    checks++; if (addr_log.size() - a != N) begin errors++; $display("FAIL long_reads got=%0d want=%0d", addr_log.size() - a, N); end
    for (int i = 0; i < N && b + i < got.size(); i++) begin
      model_word(mem[i], q, s);
      any_sat |= s;
      checks++; if (got[b+i] !== q) begin errors++; $display("FAIL long_data[%0d] got=%0d want=%0d", i, got[b+i], q); end
    end
    for (int i = 0; i < N && a + i < addr_log.size(); i++) begin
      checks++; if (addr_log[a+i] != i) begin errors++; $display("FAIL long_addr[%0d] got=%0d want=%0d", i, addr_log[a+i], i); end
    end
    checks++; if (occ_viol != ov)  begin errors++; $display("FAIL long_outstanding got=%0d_cycles_over_2 want=0", occ_viol - ov); end
    checks++; if (stab_viol != sv) begin errors++; $display("FAIL long_hold got=%0d_unstable want=0", stab_viol - sv); end
    checks++; if (done_cnt - d != 1) begin errors++; $display("FAIL long_done got=%0d want=1", done_cnt - d); end
    checks++; if (sat_flag !== any_sat) begin errors++; $display("FAIL long_sat got=%b want=%b", sat_flag, any_sat); end
  endtask

  task automatic test_reset_mid();
    int k, a, b, d;
    bit to, s;
    logic signed [23:0] q;
    for (int i = 0; i < N; i++) mem[i] = rand_acc();
    b = got.size();
    @(posedge clk); #1;
    start = 1'b1; num_samples = 12'd2048; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    to = 1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (got.size() - b >= 100) begin
        to = 0;
        break;
      end
    end
    checks++; if (to) begin errors++; $display("FAIL mid_timeout got=%0d_words want=100", got.size() - b); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", busy); end
    for (int i = 0; i < 100 && b + i < got.size(); i++) begin
      model_word(mem[i], q, s);
      checks++; if (got[b+i] !== q) begin errors++; $display("FAIL mid_data[%0d] got=%0d want=%0d", i, got[b+i], q); end
    end
    d = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_m_valid got=%b want=0", m_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    repeat (10) @(negedge clk); #1;
    checks++; if (done_cnt != d) begin errors++; $display("FAIL mid_rst_done got=%0d want=0", done_cnt - d); end
    for (int i = 0; i < 3; i++) mem[i] = rand_acc();
    a = addr_log.size(); b = got.size();
    run_sweep(3, 100, 50, k, to);
    checks++; if (to) begin errors++; $display("FAIL mid_restart_timeout got=no_done want=done"); end
    checks++; if (got.size() - b != 3)      begin errors++; $display("FAIL mid_restart_count got=%0d want=3", got.size() - b); end
    checks++; if (addr_log.size() - a != 3) begin errors++; $display("FAIL mid_restart_reads got=%0d want=3", addr_log.size() - a); end
    for (int i = 0; i < 3 && b + i < got.size(); i++) begin
      model_word(mem[i], q, s);
      checks++; if (got[b+i] !== q) begin errors++; $display("FAIL mid_restart_data[%0d] got=%0d want=%0d", i, got[b+i], q); end
    end
    for (int i = 0; i < 3 && a + i < addr_log.size(); i++) begin
      checks++; if (addr_log[a+i] != i) begin errors++; $display("FAIL mid_restart_addr[%0d] got=%0d want=%0d", i, addr_log[a+i], i); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_round();
    test_empty();
    test_long();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
